// File: rtl/comp_sched_pkg.sv
// Shared types for the comparator scheduler.
// State encoding and default timeout.
package comp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/comp_sched_sync2.sv
// Two-flop synchronizer for the comparator
// done line, which is asynchronous to clk.
module comp_sched_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // Two-stage capture; both flops clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/comp_sched.sv
// Round-robin scheduler sharing one comparator
// among NREQ requesters with timeout on done.
module comp_sched
  import comp_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int RES_W   = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        resp_valid,
  output logic [RES_W-1:0]       resp_data,
  output logic                   resp_err,
  output logic                   unit_fault,
  output logic                   unit_enable,
  output logic [DATA_W-1:0]      unit_data,
  input  logic [RES_W-1:0]       unit_ab,
  input  logic                   unit_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE =
    {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [RES_W-1:0]    cap_q, cap_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     rv_q, rv_d;
  logic [RES_W-1:0]    rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic                fault_q, fault_d;
  logic                en_q, en_d;
  logic [DATA_W-1:0]   udata_q, udata_d;

  logic                done_s;
  logic                hit;
  logic [PW-1:0]       pick;
  logic                tmo;
  int                  j;

  comp_sched_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (unit_done),
    .q   (done_s)
  );

  // Round-robin pick: first set request after ptr.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    j    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!hit && req[j]) begin
        hit  = 1'b1;
        pick = PW'(j);
      end
    end
  end

  assign tmo = (timer_q == TW'(TIMEOUT - 1));

  // Next-state and next register values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    cap_d   = cap_q;
    grant_d = '0;
    rv_d    = '0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    fault_d = fault_q;
    en_d    = en_q;
    udata_d = udata_q;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          grant_d = ONE << pick;
          udata_d =
            req_data[int'(pick)*DATA_W +: DATA_W];
          idx_d   = pick;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        en_d    = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (done_s) begin
          cap_d   = unit_ab;
          en_d    = 1'b0;
          timer_d = '0;
          state_d = S_WAIT_LO;
        end else if (tmo) begin
          en_d    = 1'b0;
          rv_d    = ONE << idx_q;
          rdata_d = '0;
          rerr_d  = 1'b1;
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!done_s) begin
          rv_d    = ONE << idx_q;
          rdata_d = cap_q;
          rerr_d  = 1'b0;
          state_d = S_RESP;
        end else if (tmo) begin
          rv_d    = ONE << idx_q;
          rdata_d = '0;
          rerr_d  = 1'b1;
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        rdata_d = '0;
        rerr_d  = 1'b0;
        ptr_d   = idx_q;
        state_d = S_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any
  // transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      idx_q   <= '0;
      timer_q <= '0;
      cap_q   <= '0;
      grant_q <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      fault_q <= 1'b0;
      en_q    <= 1'b0;
      udata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      cap_q   <= cap_d;
      grant_q <= grant_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      fault_q <= fault_d;
      en_q    <= en_d;
      udata_q <= udata_d;
    end
  end

  assign grant       = grant_q;
  assign resp_valid  = rv_q;
  assign resp_data   = rdata_q;
  assign resp_err    = rerr_q;
  assign unit_fault  = fault_q;
  assign unit_enable = en_q;
  assign unit_data   = udata_q;

endmodule
